// File: rtl/abs_diff_accum.sv
// Purpose : multi-lane sum-of-absolute-differences accumulator; sums per-lane |A-B| over an in_last-delimited packet.
// Latency : two register stages; the last beat accepted in cycle N gives out_valid in cycle N+2.
// Backpressure: en = !out_valid | out_ready drives in_ready; while a result waits, both stages and the accumulator freeze.
//
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   input beat handshake; in_a/in_b carry LANES operands, lane i at [i*WIDTH +: WIDTH]
//   in_last             marks the final beat of a packet
//   out_valid/out_ready result handshake; out_sad = packet SAD, out_beats = beat count (wraps at CNT_W)
//   out_ovf             sticky per-packet saturation flag (tied 0 unless ABS_DIFF_ACCUM_SAT_EN is defined)
//
// Build option: define ABS_DIFF_ACCUM_SAT_EN to saturate the accumulator at 2^ACC_W-1 and report out_ovf.
// Without it, the accumulator wraps modulo 2^ACC_W.
// ACC_W must be >= WIDTH + clog2(LANES) so that a single beat's lane sum cannot overflow.
module abs_diff_accum #(
    parameter int WIDTH      = 16,
    parameter int LANES      = 4,
    parameter int ACC_W      = 32,
    parameter int CNT_W      = 16,
    parameter int SIGNED_OPS = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*WIDTH-1:0] in_a,
    input  logic [LANES*WIDTH-1:0] in_b,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ACC_W-1:0]       out_sad,
    output logic [CNT_W-1:0]       out_beats,
    output logic                   out_ovf
);

    // Sign-extends into WIDTH+1 bits, so one subtraction covers both signed and unsigned operands.
    // The magnitude always fits in WIDTH bits; the clip only guards the top bit.
    function automatic logic [WIDTH-1:0] abs_diff(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH:0] ea;
        logic [WIDTH:0] eb;
        logic [WIDTH:0] d;
        ea = {(SIGNED_OPS != 0) & a[WIDTH-1], a};
        eb = {(SIGNED_OPS != 0) & b[WIDTH-1], b};
        if ($signed(ea) >= $signed(eb))
            d = ea - eb;
        else
            d = eb - ea;
        return d[WIDTH] ? {WIDTH{1'b1}} : d[WIDTH-1:0];
    endfunction

    logic                 en;
    logic [WIDTH-1:0]     diff_d [LANES];
    logic [WIDTH-1:0]     diff_q [LANES];
    logic                 s1_valid;
    logic                 s1_last;
    logic [ACC_W-1:0]     lanesum;
    logic [ACC_W-1:0]     acc;
    logic [ACC_W-1:0]     acc_next;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_next;
    logic                 load_res;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign diff_d[i] = abs_diff(in_a[i*WIDTH +: WIDTH], in_b[i*WIDTH +: WIDTH]);
    end

    // Stage 1: register per-lane differences.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            for (int i = 0; i < LANES; i++)
                diff_q[i] <= '0;
        end else if (en) begin
            s1_valid <= in_valid;
            s1_last  <= in_last;
            for (int i = 0; i < LANES; i++)
                diff_q[i] <= diff_d[i];
        end
    end

    always_comb begin
        lanesum = '0;
        for (int i = 0; i < LANES; i++)
            lanesum = lanesum + ACC_W'(diff_q[i]);
    end

    assign cnt_next = cnt + CNT_W'(1);
    assign load_res = en && s1_valid && s1_last;

`ifdef ABS_DIFF_ACCUM_SAT_EN
    logic [ACC_W:0] sum_ext;
    logic           ovf_acc;
    logic           ovf_next;
    logic           ovf_out;

    assign sum_ext  = {1'b0, acc} + {1'b0, lanesum};
    assign acc_next = sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
    assign ovf_next = ovf_acc || sum_ext[ACC_W];

    // Sticky flag follows the accumulator: cleared at packet end, captured with the result.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_acc <= 1'b0;
            ovf_out <= 1'b0;
        end else if (en && s1_valid) begin
            if (s1_last) begin
                ovf_out <= ovf_next;
                ovf_acc <= 1'b0;
            end else begin
                ovf_acc <= ovf_next;
            end
        end
    end

    assign out_ovf = ovf_out;
`else
    assign acc_next = acc + lanesum;
    assign out_ovf  = 1'b0;
`endif

    // Stage 2: accumulate and present the packet result.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_sad   <= '0;
            out_beats <= '0;
        end else begin
            // A fresh load in the same cycle as a handoff keeps out_valid high.
            if (out_valid && out_ready && !load_res)
                out_valid <= 1'b0;
            if (en && s1_valid) begin
                if (s1_last) begin
                    out_sad   <= acc_next;
                    out_beats <= cnt_next;
                    out_valid <= 1'b1;
                    acc       <= '0;
                    cnt       <= '0;
                end else begin
                    acc <= acc_next;
                    cnt <= cnt_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_abs_diff_accum.sv
// Purpose : scoreboard bench for abs_diff_accum; two instances share handshakes (unsigned 16-bit and signed 8-bit/narrow acc).
// Latency : expectations queued at beat acceptance, popped by a monitor at each output transfer.
// Backpressure: out_ready driven by a mode-controlled background process (always, random, held low).
module tb_abs_diff_accum;
    localparam int W   = 16;
    localparam int L   = 4;
    localparam int AW  = 32;
    localparam int CW  = 16;
    localparam int W2  = 8;
    localparam int AW2 = 11;
    localparam int CW2 = 4;

    typedef struct {
        longint sad;
        longint beats;
        bit     ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic           in_valid  = 1'b0;
    logic           in_last   = 1'b0;
    logic           out_ready = 1'b1;
    logic [L*W-1:0] in_a      = '0;
    logic [L*W-1:0] in_b      = '0;
    logic [L*W2-1:0] a2;
    logic [L*W2-1:0] b2;

    logic           rdy1, ov1, ovf1;
    logic [AW-1:0]  sad1;
    logic [CW-1:0]  beats1;
    logic           rdy2, ov2, ovf2;
    logic [AW2-1:0] sad2;
    logic [CW2-1:0] beats2;

    // Narrow instance sees the low byte of every wide lane.
    always_comb begin
        a2 = '0;
        b2 = '0;
        for (int i = 0; i < L; i++) begin
            a2[i*W2 +: W2] = in_a[i*W +: W2];
            b2[i*W2 +: W2] = in_b[i*W +: W2];
        end
    end

    abs_diff_accum #(.WIDTH(W), .LANES(L), .ACC_W(AW), .CNT_W(CW), .SIGNED_OPS(0)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_a(in_a), .in_b(in_b),
        .in_last(in_last), .out_valid(ov1), .out_ready(out_ready), .out_sad(sad1),
        .out_beats(beats1), .out_ovf(ovf1));

    abs_diff_accum #(.WIDTH(W2), .LANES(L), .ACC_W(AW2), .CNT_W(CW2), .SIGNED_OPS(1)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2), .in_a(a2), .in_b(b2),
        .in_last(in_last), .out_valid(ov2), .out_ready(out_ready), .out_sad(sad2),
        .out_beats(beats2), .out_ovf(ovf2));

    int     errors = 0;
    int     checks = 0;
    int     bp_mode = 0;
    exp_t   q1[$];
    exp_t   q2[$];
    longint tot1 = 0;
    longint tot2 = 0;
    longint nb   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint diff_u(input logic [W-1:0] a, input logic [W-1:0] b);
        longint x = longint'(a);
        longint y = longint'(b);
        return (x > y) ? x - y : y - x;
    endfunction

    function automatic longint diff_s(input logic [W2-1:0] a, input logic [W2-1:0] b);
        longint x = longint'($signed(a));
        longint y = longint'($signed(b));
        return (x > y) ? x - y : y - x;
    endfunction

    // Packet result from the exact total: saturation of a monotone sum is min(total, max).
    function automatic exp_t make_exp(input longint tot, input longint beats, input int aw, input int cw);
        exp_t   e;
        longint maxv = (longint'(1) << aw) - 1;
`ifdef ABS_DIFF_ACCUM_SAT_EN
        e.sad = (tot > maxv) ? maxv : tot;
        e.ovf = (tot > maxv);
`else
        e.sad = tot % (maxv + 1);
        e.ovf = 1'b0;
`endif
        e.beats = beats % (longint'(1) << cw);
        return e;
    endfunction

    task automatic record_beat();
        for (int i = 0; i < L; i++) begin
            tot1 += diff_u(in_a[i*W +: W], in_b[i*W +: W]);
            tot2 += diff_s(a2[i*W2 +: W2], b2[i*W2 +: W2]);
        end
        nb++;
        if (in_last) begin
            q1.push_back(make_exp(tot1, nb, AW, CW));
            q2.push_back(make_exp(tot2, nb, AW2, CW2));
            tot1 = 0;
            tot2 = 0;
            nb   = 0;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_beat(input logic [L*W-1:0] a, input logic [L*W-1:0] b, input logic last);
        bit acc = 1'b0;
        in_a = a;
        in_b = b;
        in_last = last;
        in_valid = 1'b1;
        for (int k = 0; k < 200 && !acc; k++) begin
            @(negedge clk);
            if (rdy1) begin
                acc = 1'b1;
                record_beat();
            end
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: beat not accepted within 200 cycles");
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        q1.delete();
        q2.delete();
        tot1 = 0;
        tot2 = 0;
        nb   = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic logic [W-1:0] rand_lane();
        case ($urandom_range(0, 5))
            0: return 16'h0000;
            1: return 16'hFFFF;
            2: return 16'h8000;
            3: return 16'h7F80;
            default: return W'($urandom);
        endcase
    endfunction

    function automatic logic [L*W-1:0] rep(input logic [W-1:0] v);
        return {L{v}};
    endfunction

    // out_ready driver: 0 = always ready, 1 = random, 2 = held low.
    initial forever begin
        @(posedge clk);
        #2;
        case (bp_mode)
            0: out_ready = 1'b1;
            1: out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
        endcase
    end

    // Monitor: a transfer happens at the next edge when valid & ready at the falling edge.
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst && ov1 && out_ready) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut1_unexpected: result sad=%0d with no packet pending", sad1);
            end else begin
                e = q1.pop_front();
                chk("dut1_sad", 64'(sad1), e.sad);
                chk("dut1_beats", 64'(beats1), e.beats);
                chk("dut1_ovf", 64'(ovf1), 64'(e.ovf));
            end
        end
        if (!rst && ov2 && out_ready) begin
            if (q2.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut2_unexpected: result sad=%0d with no packet pending", sad2);
            end else begin
                e = q2.pop_front();
                chk("dut2_sad", 64'(sad2), e.sad);
                chk("dut2_beats", 64'(beats2), e.beats);
                chk("dut2_ovf", 64'(ovf2), 64'(e.ovf));
            end
        end
    end

    initial begin
        logic [L*W-1:0] a;
        logic [L*W-1:0] b;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_in_ready", 64'(rdy1), 1);
        chk("rst_out_valid", 64'(ov1), 0);
        chk("rst_out_sad", 64'(sad1), 0);
        chk("rst_out_beats", 64'(beats1), 0);
        chk("rst_out_ovf", 64'(ovf2), 0);

        // Single-beat packet with latency check.
        a = {16'h0005, 16'h0005, 16'h0005, 16'h1234};
        b = {16'h0005, 16'h0005, 16'h0005, 16'h0234};
        send_beat(a, b, 1'b1);
        chk("lat_cycle1_valid", 64'(ov1), 0);
        @(posedge clk);
        #1;
        chk("lat_cycle2_valid", 64'(ov1), 1);
        chk("single_sad", 64'(sad1), 64'h1000);
        chk("single_beats", 64'(beats1), 1);

        // Three-beat packet including the 0 vs max extreme.
        send_beat(rep(16'd10), rep(16'd3), 1'b0);
        send_beat(rep(16'd3), rep(16'd10), 1'b0);
        send_beat(rep(16'd0), rep(16'hFFFF), 1'b1);

        // Signed extreme on lane 0: narrow instance sees -128 vs 127.
        send_beat({16'd7, 16'd7, 16'd7, 16'h0080}, {16'd7, 16'd7, 16'd7, 16'h007F}, 1'b1);

        // Narrow accumulator overflow: 255 per lane, 3 beats.
        send_beat(rep(16'h007F), rep(16'h0080), 1'b0);
        send_beat(rep(16'h0080), rep(16'h007F), 1'b0);
        send_beat(rep(16'h007F), rep(16'h0080), 1'b1);
        repeat (4) @(posedge clk);
        #1;

        // Backpressure: first result held while the next packet sits in the pipe.
        bp_mode = 2;
        send_beat(a, b, 1'b1);
        send_beat(rep(16'd10), rep(16'd3), 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("stall_in_ready", 64'(rdy1), 0);
            chk("stall_sad", 64'(sad1), 64'h1000);
            @(posedge clk);
            #1;
        end
        bp_mode = 0;
        send_beat(rep(16'd3), rep(16'd10), 1'b1);
        repeat (4) @(posedge clk);
        #1;

        // Reset mid-packet, then a fresh single-beat packet.
        send_beat(rep(16'h1111), rep(16'h0001), 1'b0);
        send_beat(rep(16'h2222), rep(16'h0001), 1'b0);
        do_reset();
        send_beat({48'h0, 16'd9}, {48'h0, 16'd4}, 1'b1);
        repeat (4) @(posedge clk);
        #1;

        // Randomized traffic with random backpressure and bubbles.
        bp_mode = 1;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            for (int i = 0; i < L; i++) begin
                a[i*W +: W] = rand_lane();
                b[i*W +: W] = rand_lane();
            end
            send_beat(a, b, ($urandom_range(0, 7) == 0));
        end
        send_beat(rep(16'd1), rep(16'd2), 1'b1);

        bp_mode = 0;
        for (int k = 0; k < 200 && (q1.size() != 0 || q2.size() != 0); k++)
            @(posedge clk);
        @(posedge clk);
        #1;
        chk("drain_q1", 64'(q1.size()), 0);
        chk("drain_q2", 64'(q2.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
